// File: rtl/io_tile_chain.sv
// io_tile_chain: parametrised IO tile between pad ring and interconnect.
// Configuration is loaded LSB-first through a serial scan chain. All routed outputs stay at
// zero until a complete image has been shifted in and the shift enable has dropped.
// Optional feature: define IO_TILE_INPUT_SYNC_EN to put a 2-flop synchroniser on each pad
// input ahead of the IC muxes.
module io_tile_chain #(
  parameter int unsigned IO_PAIRS = 4,
  parameter int unsigned IC_WIDTH = 6
) (
  input  logic                clock,
  input  logic                nreset,
  input  logic [IO_PAIRS-1:0] data_from_io,
  output logic [IO_PAIRS-1:0] data_to_io,
  output logic [IO_PAIRS-1:0] io_oe,
  input  logic [IC_WIDTH-1:0] data_from_ic,
  output logic [IC_WIDTH-1:0] data_to_ic,
  input  logic                config_enable,
  input  logic                config_in,
  output logic                config_out,
  output logic                config_valid
);

  localparam int unsigned SEL_IC       = ($clog2(IO_PAIRS) > 0) ? $clog2(IO_PAIRS) : 1;
  localparam int unsigned SEL_IO       = ($clog2(IC_WIDTH) > 0) ? $clog2(IC_WIDTH) : 1;
  localparam int unsigned FIELD_W      = SEL_IO + 2;
  localparam int unsigned IO_BASE      = IC_WIDTH * SEL_IC;
  localparam int unsigned CONFIG_WIDTH = IO_BASE + IO_PAIRS * FIELD_W;
  localparam int unsigned CNT_W        = $clog2(CONFIG_WIDTH + 1);
  // Mux sources padded to a power of two so out-of-range selects read a zero.
  localparam int unsigned IO_EXT_W     = 1 << SEL_IC;
  localparam int unsigned IC_EXT_W     = 1 << SEL_IO;

  localparam logic [CNT_W-1:0] CntFull = CNT_W'(CONFIG_WIDTH);

  logic [CONFIG_WIDTH-1:0] config_q, config_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    prev_en_q, prev_en_d;
  logic                    valid_q, valid_d;
  logic [IO_PAIRS-1:0]     io_reg_q, io_reg_d;

  logic [IO_PAIRS-1:0] io_src;
  logic [IO_EXT_W-1:0] io_ext;
  logic [IC_EXT_W-1:0] ic_ext;
  logic [IC_WIDTH-1:0] ic_mux;
  logic [IO_PAIRS-1:0] io_mux;
  logic [IO_PAIRS-1:0] reg_en;
  logic [IO_PAIRS-1:0] oe;

`ifdef IO_TILE_INPUT_SYNC_EN
  logic [IO_PAIRS-1:0] sync1_q, sync2_q;

  // Two-stage synchroniser on the pad inputs; runs independent of config state.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= data_from_io;
      sync2_q <= sync1_q;
    end
  end

  assign io_src = sync2_q;
`else
  assign io_src = data_from_io;
`endif

  // Chain shift, load counter and validity next-state.
  always_comb begin
    config_d  = config_q;
    count_d   = count_q;
    prev_en_d = config_enable;
    if (config_enable) begin
      config_d = {config_in, config_q[CONFIG_WIDTH-1:1]};
      if (!prev_en_q) begin
        count_d = CNT_W'(1);
      end else if (count_q != CntFull) begin
        count_d = count_q + CNT_W'(1);
      end
    end
    valid_d = !config_enable && (count_q == CntFull);
  end

  // Configuration state; reset discards any partial load.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      config_q  <= '0;
      count_q   <= '0;
      prev_en_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      config_q  <= config_d;
      count_q   <= count_d;
      prev_en_q <= prev_en_d;
      valid_q   <= valid_d;
    end
  end

  assign io_ext = IO_EXT_W'(io_src);
  assign ic_ext = IC_EXT_W'(data_from_ic);

  for (genvar i = 0; i < IC_WIDTH; i++) begin : g_ic
    logic [SEL_IC-1:0] sel;
    assign sel       = config_q[i*SEL_IC +: SEL_IC];
    assign ic_mux[i] = io_ext[sel];
  end

  for (genvar j = 0; j < IO_PAIRS; j++) begin : g_io
    logic [SEL_IO-1:0] sel;
    assign sel       = config_q[IO_BASE + j*FIELD_W +: SEL_IO];
    assign io_mux[j] = ic_ext[sel];
    assign reg_en[j] = config_q[IO_BASE + j*FIELD_W + SEL_IO];
    assign oe[j]     = config_q[IO_BASE + j*FIELD_W + SEL_IO + 1];
  end

  // Optional pad output register, cleared whenever the configuration is not active.
  always_comb begin
    io_reg_d = valid_q ? io_mux : '0;
  end

  // Pad output register state.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      io_reg_q <= '0;
    end else begin
      io_reg_q <= io_reg_d;
    end
  end

  // Routed outputs are gated by validity so partial images never drive pads or tracks.
  always_comb begin
    data_to_ic = valid_q ? ic_mux : '0;
    data_to_io = valid_q ? ((reg_en & io_reg_q) | (~reg_en & io_mux)) : '0;
    io_oe      = valid_q ? oe : '0;
  end

  assign config_out   = config_q[0];
  assign config_valid = valid_q;

endmodule

// File: tb/tb_io_tile_chain.sv
// Directed bench for io_tile_chain (default parameters, 32-bit image).
module tb_io_tile_chain;

  logic       clock = 1'b0;
  logic       nreset;
  logic [3:0] data_from_io;
  logic [3:0] data_to_io;
  logic [3:0] io_oe;
  logic [5:0] data_from_ic;
  logic [5:0] data_to_ic;
  logic       config_enable;
  logic       config_in;
  logic       config_out;
  logic       config_valid;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] chain = '0;  // model of the config shift register

  // Image layout: [11:0] six 2-bit IC selects; from bit 12, per pad {oe, reg_en, sel_io[2:0]}.
  localparam logic [31:0] Img1 = 32'h00B7_F1E4;  // io_oe = 0011
  localparam logic [31:0] Img2 = 32'h003F_5002;  // ic0<-io2; io0<-ic5 comb oe; io1 sel 7 reg oe
  localparam logic [31:0] Img3 = 32'h0033_5002;  // as Img2 but io1 sel 1
  localparam logic [31:0] Img4 = 32'h8421_0000;  // all sel 0, all oe, no reg

  io_tile_chain #(
    .IO_PAIRS(4),
    .IC_WIDTH(6)
  ) dut (
    .clock        (clock),
    .nreset       (nreset),
    .data_from_io (data_from_io),
    .data_to_io   (data_to_io),
    .io_oe        (io_oe),
    .data_from_ic (data_from_ic),
    .data_to_ic   (data_to_ic),
    .config_enable(config_enable),
    .config_in    (config_in),
    .config_out   (config_out),
    .config_valid (config_valid)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Shift n bits of stream LSB first, checking the serial output against the model.
  task automatic shift_bits(input logic [63:0] stream, input int n);
    config_enable = 1'b1;
    for (int i = 0; i < n; i++) begin
      check_eq("cfg_out", {31'b0, config_out}, {31'b0, chain[0]});
      config_in = stream[i];
      tick();
      chain = {stream[i], chain[31:1]};
    end
  endtask

  task automatic finish_load();
    check_eq("valid_pre", {31'b0, config_valid}, 32'd0);
    config_enable = 1'b0;
    tick();
    check_eq("valid_rise", {31'b0, config_valid}, 32'd1);
  endtask

  task automatic all_zero(input string tag);
    check_eq({tag, "_to_io"}, {28'b0, data_to_io}, 32'd0);
    check_eq({tag, "_oe"}, {28'b0, io_oe}, 32'd0);
    check_eq({tag, "_to_ic"}, {26'b0, data_to_ic}, 32'd0);
    check_eq({tag, "_valid"}, {31'b0, config_valid}, 32'd0);
  endtask

  // Drive pad inputs and check the IC outputs with the pad-to-IC latency of the build.
  task automatic io_to_ic(input logic [3:0] io, input logic [5:0] old_v, input logic [5:0] exp_v);
    data_from_io = io;
`ifdef IO_TILE_INPUT_SYNC_EN
    #1 check_eq("ic_lat0", {26'b0, data_to_ic}, {26'b0, old_v});
    tick();
    check_eq("ic_lat1", {26'b0, data_to_ic}, {26'b0, old_v});
    tick();
    check_eq("ic_lat2", {26'b0, data_to_ic}, {26'b0, exp_v});
`else
    #1 check_eq("ic_comb", {26'b0, data_to_ic}, {26'b0, exp_v});
    check_eq("ic_comb_old", {26'b0, old_v}, {26'b0, old_v} ^ 32'd0);
`endif
  endtask

  initial begin
    nreset        = 1'b0;
    config_enable = 1'b0;
    config_in     = 1'b0;
    data_from_ic  = 6'h3F;
    data_from_io  = 4'hF;
    repeat (3) tick();
    #2 nreset = 1'b1;
    repeat (4) tick();
    // Reset then idle.
    all_zero("idle");
    check_eq("idle_cfg_out", {31'b0, config_out}, 32'd0);

    // Full load of Img1.
    shift_bits({32'b0, Img1}, 32);
    finish_load();
    check_eq("img1_oe", {28'b0, io_oe}, 32'h3);

    // Img2: readback of Img1 through config_out while shifting.
    data_from_io = 4'h0;
    data_from_ic = 6'h00;
    shift_bits({32'b0, Img2}, 32);
    finish_load();
    repeat (3) tick();
    check_eq("img2_oe", {28'b0, io_oe}, 32'h3);
    check_eq("img2_ic0", {26'b0, data_to_ic}, 32'h0);
    io_to_ic(4'b0100, 6'b000000, 6'b000001);
    io_to_ic(4'b0001, 6'b000001, 6'b111110);
    io_to_ic(4'b0000, 6'b111110, 6'b000000);
    data_from_ic = 6'h20;
    #1 check_eq("io0_comb", {28'b0, data_to_io}, 32'b0001);
    data_from_ic = 6'h21;
    #1 check_eq("io_mix", {28'b0, data_to_io}, 32'b1101);
    tick();
    check_eq("io1_oor", {28'b0, data_to_io}, 32'b1101);
    data_from_ic = 6'h00;

    // Img3: io1 registered from ic1.
    shift_bits({32'b0, Img3}, 32);
    finish_load();
    data_from_ic = 6'h02;
    #1 check_eq("io1_reg_lag", {28'b0, data_to_io}, 32'b0000);
    tick();
    check_eq("io1_reg_on", {28'b0, data_to_io}, 32'b0010);
    data_from_ic = 6'h00;
    #1 check_eq("io1_reg_hold", {28'b0, data_to_io}, 32'b0010);
    tick();
    check_eq("io1_reg_off", {28'b0, data_to_io}, 32'b0000);

    // Undershift: 20 bits never validate.
    data_from_io = 4'hF;
    data_from_ic = 6'h3F;
    shift_bits(64'hF_FFFF, 20);
    config_enable = 1'b0;
    repeat (3) tick();
    all_zero("under");

    // Overshift: 40 bits, last 32 are Img2.
    shift_bits({24'b0, Img2, 8'hA5}, 40);
    finish_load();
    repeat (3) tick();
    check_eq("over_oe", {28'b0, io_oe}, 32'h3);
    check_eq("over_ic", {26'b0, data_to_ic}, 32'h3F);
    check_eq("over_io", {28'b0, data_to_io}, 32'b1101);

    // Reset mid-shift.
    data_from_io = 4'h0;
    data_from_ic = 6'h00;
    shift_bits({32'b0, Img4}, 10);
    #2 nreset = 1'b0;
    #1 all_zero("rst_shift");
    check_eq("rst_shift_cfg", {31'b0, config_out}, 32'd0);
    chain = '0;
    #2 nreset = 1'b1;
    config_enable = 1'b0;
    repeat (3) tick();
    all_zero("rst_shift_after");

    // Full load of Img4, then reset while valid.
    shift_bits({32'b0, Img4}, 32);
    finish_load();
    data_from_io = 4'hF;
    data_from_ic = 6'h01;
    repeat (3) tick();
    check_eq("img4_oe", {28'b0, io_oe}, 32'hF);
    check_eq("img4_ic", {26'b0, data_to_ic}, 32'h3F);
    check_eq("img4_io", {28'b0, data_to_io}, 32'hF);
    #2 nreset = 1'b0;
    #1 all_zero("rst_valid");
    check_eq("rst_valid_cfg", {31'b0, config_out}, 32'd0);
    #2 nreset = 1'b1;
    repeat (3) tick();
    all_zero("rst_valid_after");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/io_tile_chain.md
Name: io_tile_chain

Overview:
- Parametrised next-generation IO tile, sitting between the pad ring and the interconnect (IC).
- Generalises the fixed 4-IO / 6-IC tile to IO_PAIRS pads and IC_WIDTH tracks.
- Owns its configuration as a serial scan chain with load tracking; routing stays gated off until a full load completes.
- Adds per-pad output enable and an optional output register on each pad output.

Parameters:
- IO_PAIRS, 4, number of pads, each with in/out/oe.
- IC_WIDTH, 6, number of IC tracks in each direction.
- Derived (not overridable):
  - SEL_IC = max(1, clog2(IO_PAIRS)).
  - SEL_IO = max(1, clog2(IC_WIDTH)).
  - CONFIG_WIDTH = IC_WIDTH*SEL_IC + IO_PAIRS*(SEL_IO+2). Default = 32.

Ports:
- clock  in  1  single tile clock.
- nreset  in  1  asynchronous, active-low reset.
- data_from_io  in  IO_PAIRS  pad input values.
- data_to_io  out  IO_PAIRS  pad output values.
- io_oe  out  IO_PAIRS  pad output enables, 1 = drive.
- data_from_ic  in  IC_WIDTH  tracks from interconnect.
- data_to_ic  out  IC_WIDTH  tracks to interconnect.
- config_enable  in  1  shift enable for the config chain.
- config_in  in  1  serial config data in.
- config_out  out  1  serial config data out, to the next tile.
- config_valid  out  1  a complete configuration is loaded and active.

Behaviour:
- Reset (nreset low, async): config_reg, counter, prev_enable, output regs, config_valid all 0. Hence data_to_io = 0, io_oe = 0, data_to_ic = 0, config_out = 0. Reset mid-load discards the partial load.
- Chain shifting:
  - When config_enable is 1 at a clock edge: config_reg <= {config_in, config_reg[CONFIG_WIDTH-1:1]}.
  - config_out = config_reg[0] (registered, no combinational path from config_in).
  - The LSB of the image is sent first.
- Load counter: width clog2(CONFIG_WIDTH+1).
  - First enabled cycle after a cycle with config_enable = 0: count <= 1.
  - Further enabled cycles: count increments, saturating at CONFIG_WIDTH.
  - Disabled cycles: count holds.
- config_valid (flop) <= (!config_enable && count == CONFIG_WIDTH). It rises one cycle after the last shift with enable dropped, and falls on the first enabled edge.
- Overshift: more than CONFIG_WIDTH bits in one burst leaves the last CONFIG_WIDTH bits active; config_valid still asserts. Undershift keeps config_valid = 0.
- Field layout:
  - IC output i uses config_reg[i*SEL_IC +: SEL_IC] = sel_ic[i].
  - IO output j sits at base B_j = IC_WIDTH*SEL_IC + j*(SEL_IO+2):
    - [B_j +: SEL_IO] = sel_io[j]
    - [B_j+SEL_IO] = reg_en[j]
    - [B_j+SEL_IO+1] = oe[j]
- IC path: data_to_ic[i] = config_valid ? io_src[sel_ic[i]] : 0.
  - io_src is data_from_io, or its synchronised copy (see Optional Feature).
  - sel_ic >= IO_PAIRS gives 0.
- IO path: m[j] = data_from_ic[sel_io[j]]; sel_io >= IC_WIDTH gives 0.
  - Output register: q[j] <= config_valid ? m[j] : 0 every clock.
  - data_to_io[j] = !config_valid ? 0 : (reg_en[j] ? q[j] : m[j]).
  - With reg_en: 1-cycle latency. Without: combinational, 0 latency.
- io_oe[j] = config_valid & oe[j].
- While config_enable is high (config_valid = 0), all routed outputs are 0. This prevents pad contention from partially shifted images.

Optional Feature:
- Macro: IO_TILE_INPUT_SYNC_EN.
- Defined:
  - data_from_io passes through a 2-flop synchroniser per pad (reset 0) before the IC muxes.
  - Pad-to-IC latency is 2 cycles.
  - Synchroniser flops run regardless of config_valid.
- Undefined:
  - io_src = data_from_io directly.
  - Pad-to-IC is combinational, latency 0.

Test Plan:
- Reset then idle, data_from_ic = 6'h3F, data_from_io = 4'hF → all outputs 0, config_valid = 0.
- Shift 32-bit image 0x0B7F_1E4 padded to 32 bits, LSB first, then drop enable → config_valid = 1 exactly one cycle later. config_out replays shifted bits delayed by 32 cycles. Readback matches.
- Image with sel_ic[0] = 2 and IO0: sel_io = 5, reg_en = 0, oe = 1. Toggle data_from_io[2] and data_from_ic[5] → data_to_ic[0] follows at 0 cycles (2 with sync macro); data_to_io[0] follows at 0 cycles; io_oe[0] = 1.
- IO1 with reg_en = 1, sel_io = 7 (out of range), then sel_io = 1 → data_to_io[1] = 0 for the out-of-range image; with sel 1 it lags data_from_ic[1] by exactly 1 cycle.
- Shift only 20 bits, then drop enable → config_valid stays 0 and outputs stay 0. Re-assert enable and shift 40 bits → valid, with the last 32 bits active.
- Assert nreset low mid-shift, and separately while valid with io_oe = 4'hF → all outputs 0 asynchronously, before the next clock edge. After release, config_valid = 0 until a full reload.
